// File: rtl/mem_region_ctrl_if.sv
// CPU-side memory bus for mem_region_ctrl: request/address/direction in,
// registered region selects and the ready/err completion pulse out.
interface mem_region_ctrl_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              rom_sel;
    logic              ram_sel;
    logic              io_sel;
    logic              ready;
    logic              err;

    modport master (
        output req, addr, we,
        input  rom_sel, ram_sel, io_sel, ready, err
    );

    modport slave (
        input  req, addr, we,
        output rom_sel, ram_sel, io_sel, ready, err
    );
endinterface

// File: rtl/mem_region_ctrl.sv
// ROM/RAM/IO region decoder with registered selects and per-region wait states.
// Optional ROM write protection is enabled by defining ROM_WP_EN.
module mem_region_ctrl #(
    parameter int unsigned          ADDR_W   = 13,
    parameter logic [ADDR_W-1:0]    RAM_BASE = 13'h1800,
    parameter int unsigned          IO_SIZE  = 0,
    parameter int unsigned          ROM_WAIT = 1,
    parameter int unsigned          RAM_WAIT = 0,
    parameter int unsigned          IO_WAIT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_region_ctrl_if.slave   bus
);
    localparam int unsigned MAX_WAIT = (ROM_WAIT > RAM_WAIT)
        ? ((ROM_WAIT > IO_WAIT) ? ROM_WAIT : IO_WAIT)
        : ((RAM_WAIT > IO_WAIT) ? RAM_WAIT : IO_WAIT);
    localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    // One bit wider than the address so IO_SIZE = 0 puts the IO base past the map.
    localparam logic [ADDR_W:0] IO_BASE = {1'b1, {ADDR_W{1'b0}}} - (ADDR_W+1)'(IO_SIZE);

    localparam logic [CNT_W-1:0] ROM_W = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_W = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_W  = CNT_W'(IO_WAIT);

    generate
        if (!((RAM_BASE != '0) && ({1'b0, RAM_BASE} <= IO_BASE))) begin : g_bad_map
            $error("mem_region_ctrl: need 0 < RAM_BASE <= 2^ADDR_W - IO_SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rom_q, ram_q, io_q, ready_q;
    logic             is_io, is_ram, is_rom, wp_hit;
    logic [CNT_W-1:0] ld_cnt;

    assign is_io  = ({1'b0, bus.addr} >= IO_BASE);
    assign is_ram = !is_io && (bus.addr >= RAM_BASE);
    assign is_rom = !is_io && !is_ram;
    assign ld_cnt = is_io ? IO_W : (is_ram ? RAM_W : ROM_W);

`ifdef ROM_WP_EN
    logic err_q;
    assign wp_hit  = bus.we && is_rom;
    assign bus.err = err_q;
`else
    logic unused_we;
    assign unused_we = bus.we;
    assign wp_hit    = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rom_q   <= 1'b0;
            ram_q   <= 1'b0;
            io_q    <= 1'b0;
            ready_q <= 1'b0;
`ifdef ROM_WP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.req) begin
                    state <= BUSY;
                    if (wp_hit) begin
                        // Rejected ROM write: complete immediately, no select.
                        cnt     <= '0;
                        ready_q <= 1'b1;
`ifdef ROM_WP_EN
                        err_q   <= 1'b1;
`endif
                    end else begin
                        rom_q   <= is_rom;
                        ram_q   <= is_ram;
                        io_q    <= is_io;
                        cnt     <= ld_cnt;
                        ready_q <= (ld_cnt == '0);
                    end
                end
                BUSY: begin
                    if (ready_q) begin
                        state   <= DONE;
                        rom_q   <= 1'b0;
                        ram_q   <= 1'b0;
                        io_q    <= 1'b0;
                        ready_q <= 1'b0;
`ifdef ROM_WP_EN
                        err_q   <= 1'b0;
`endif
                    end else begin
                        // ready is registered, so raise it as the count leaves 1.
                        cnt     <= cnt - 1'b1;
                        ready_q <= (cnt == CNT_W'(1));
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rom_sel = rom_q;
    assign bus.ram_sel = ram_q;
    assign bus.io_sel  = io_q;
    assign bus.ready   = ready_q;
endmodule

// File: tb/tb_mem_region_ctrl.sv
// Directed bench: default map plus a 16-address IO map, both driven identically.
module tb_mem_region_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_region_ctrl_if #(.ADDR_W(13)) bus_a ();
    mem_region_ctrl_if #(.ADDR_W(13)) bus_b ();

    mem_region_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_region_ctrl #(.IO_SIZE(16), .IO_WAIT(2)) u_dut_io (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // {rom_sel, ram_sel, io_sel, ready, err}
    logic [4:0] oa, ob;
    assign oa = {bus_a.rom_sel, bus_a.ram_sel, bus_a.io_sel, bus_a.ready, bus_a.err};
    assign ob = {bus_b.rom_sel, bus_b.ram_sel, bus_b.io_sel, bus_b.ready, bus_b.err};

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %b exp %b (rom,ram,io,ready,err)", tag, got, exp);
        end
    endtask

    task automatic set_bus(input logic r, input logic [12:0] a, input logic w);
        bus_a.req = r; bus_a.addr = a; bus_a.we = w;
        bus_b.req = r; bus_b.addr = a; bus_b.we = w;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic gap();
        set_bus(1'b0, 13'h0, 1'b0);
        repeat (6) step();
    endtask

    initial begin
        set_bus(1'b0, 13'h0, 1'b0);
        @(negedge clk);
        repeat (2) step();
        chk("rst_a", oa, 5'b00000);
        chk("rst_b", ob, 5'b00000);
        rst = 1'b0;
        gap();

        // ROM read, then a RAM request held through DONE is only taken in IDLE
        set_bus(1'b1, 13'h17FF, 1'b0);
        step(); chk("rom_t1", oa, 5'b10000);
        step(); chk("rom_t2", oa, 5'b10010);
        set_bus(1'b1, 13'h1800, 1'b0);
        step(); chk("rom_done_t3", oa, 5'b00000);
        step(); chk("rom_idle_t4", oa, 5'b00000);
        step(); chk("ram_after_idle", oa, 5'b01010);
        gap();

        set_bus(1'b1, 13'h1800, 1'b0);
        step(); chk("ram_1800_t1", oa, 5'b01010);
        set_bus(1'b0, 13'h0, 1'b0);
        step(); chk("ram_1800_t2", oa, 5'b00000);
        gap();

        set_bus(1'b1, 13'h1FFF, 1'b0);
        step(); chk("ram_1fff_t1", oa, 5'b01010);
        set_bus(1'b0, 13'h0, 1'b0);
        step(); chk("ram_1fff_t2", oa, 5'b00000);
        gap();

        // IO region on the IO_SIZE=16 instance
        set_bus(1'b1, 13'h1FF0, 1'b0);
        step(); chk("io_t1", ob, 5'b00100);
        step(); chk("io_t2", ob, 5'b00100);
        step(); chk("io_t3", ob, 5'b00110);
        set_bus(1'b0, 13'h0, 1'b0);
        step(); chk("io_t4", ob, 5'b00000);
        gap();

        set_bus(1'b1, 13'h1FEF, 1'b0);
        step(); chk("io_edge_ram", ob, 5'b01010);
        gap();

        // address change after T0 must not move the access
        set_bus(1'b1, 13'h0000, 1'b0);
        step(); chk("addrchg_t1", oa, 5'b10000);
        set_bus(1'b1, 13'h1900, 1'b0);
        step(); chk("addrchg_t2", oa, 5'b10010);
        set_bus(1'b0, 13'h0, 1'b0);
        step(); chk("addrchg_t3", oa, 5'b00000);
        gap();

        // reset during T1 aborts, next request taken right after
        set_bus(1'b1, 13'h0000, 1'b0);
        step(); chk("abort_t1", oa, 5'b10000);
        rst = 1'b1;
        step(); chk("abort_t2", oa, 5'b00000);
        rst = 1'b0;
        set_bus(1'b1, 13'h1800, 1'b0);
        step(); chk("post_rst_ram", oa, 5'b01010);
        set_bus(1'b0, 13'h0, 1'b0);
        step(); chk("post_rst_done", oa, 5'b00000);
        gap();

        // ROM write
        set_bus(1'b1, 13'h0010, 1'b1);
`ifdef ROM_WP_EN
        step(); chk("romwr_t1", oa, 5'b00011);
        step(); chk("romwr_t2", oa, 5'b00000);
`else
        step(); chk("romwr_t1", oa, 5'b10000);
        step(); chk("romwr_t2", oa, 5'b10010);
`endif
        set_bus(1'b0, 13'h0, 1'b0);
        step(); chk("romwr_t3", oa, 5'b00000);
        gap();

        set_bus(1'b1, 13'h1800, 1'b1);
        step(); chk("ramwr_t1", oa, 5'b01010);
        gap();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
